// File: rtl/song_writer.sv
// song_writer: run-length encodes ticked note samples into {note, dur} song RAM entries
module song_writer #(
    parameter int ADDR_W = 5,
    parameter int DUR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              rec,
    input  logic [3:0]        note_in,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [3+DUR_W:0]  wdata,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W-1:0] len
);
    typedef enum logic [2:0] {IDLE, RUN, FLUSH, TERM, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [DUR_W-1:0]  DMAX = '1;
    state_t           state;
    logic [3:0]       cur_note;
    logic [DUR_W-1:0] dur;
    // len doubles as the next write address; the last address is kept for the terminator
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            cur_note <= '0;
            dur      <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
            full     <= 1'b0;
            len      <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE: if (rec) begin
                    len   <= '0;
                    dur   <= '0;
                    full  <= 1'b0;
                    busy  <= 1'b1;
                    state <= RUN;
                    if (tick) begin
                        cur_note <= note_in;
                        dur      <= DUR_W'(1);
                    end
                end
                RUN: if (!rec) state <= FLUSH;
                else if (tick) begin
                    if (dur == '0) begin
                        cur_note <= note_in;
                        dur      <= DUR_W'(1);
                    end else if (note_in == cur_note && dur != DMAX) dur <= dur + 1'b1;
                    else if (len == LAST) begin
                        full  <= 1'b1;
                        state <= TERM;
                    end else begin
                        we       <= 1'b1;
                        waddr    <= len;
                        wdata    <= {cur_note, dur};
                        len      <= len + 1'b1;
                        cur_note <= note_in;
                        dur      <= DUR_W'(1);
                    end
                end
                FLUSH: if (dur != '0 && len != LAST) begin
                    we    <= 1'b1;
                    waddr <= len;
                    wdata <= {cur_note, dur};
                    len   <= len + 1'b1;
                    state <= TERM;
                end else begin
                    we    <= 1'b1;
                    waddr <= len;
                    wdata <= '0;
                    full  <= full | (dur != '0);
                    state <= DONE;
                end
                TERM: begin
                    we    <= 1'b1;
                    waddr <= len;
                    wdata <= '0;
                    state <= DONE;
                end
                DONE: begin
                    busy <= 1'b0;
                    if (!rec) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_song_writer.sv
// tb_song_writer: scoreboard bench for song_writer (default size and an 8-entry memory)
module tb_song_writer;
    logic        clk, rst, tick, rec0, rec1;
    logic [3:0]  note_in;
    logic        we0, busy0, full0, we1, busy1, full1;
    logic [4:0]  waddr0, len0;
    logic [11:0] wdata0, wdata1;
    logic [2:0]  waddr1, len1;
    logic [31:0] q0[$], q1[$];
    int checks = 0, errors = 0;

    song_writer u0 (.clk(clk), .rst(rst), .tick(tick), .rec(rec0), .note_in(note_in), .we(we0),
                    .waddr(waddr0), .wdata(wdata0), .busy(busy0), .full(full0), .len(len0));
    song_writer #(.ADDR_W(3), .DUR_W(8)) u1 (.clk(clk), .rst(rst), .tick(tick), .rec(rec1),
                    .note_in(note_in), .we(we1), .waddr(waddr1), .wdata(wdata1), .busy(busy1),
                    .full(full1), .len(len1));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(int a, int n, int d);
        return {8'(a), 12'(0), n[3:0], d[7:0]};
    endfunction

    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            if (q0.size() == 0) chk("wr0_unexpected", {8'(waddr0), 12'(0), wdata0}, 32'hffffffff);
            else chk("wr0", {8'(waddr0), 12'(0), wdata0}, q0.pop_front());
        end
        if (we1 === 1'b1) begin
            if (q1.size() == 0) chk("wr1_unexpected", {8'(waddr1), 12'(0), wdata1}, 32'hffffffff);
            else chk("wr1", {8'(waddr1), 12'(0), wdata1}, q1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n, int note);
        for (int i = 0; i < n; i++) begin
            tick = 1;
            note_in = 4'(note);
            step();
            tick = 0;
            step();
        end
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (busy0 && n < 50) begin
            step();
            n++;
        end
        step();
        chk("busy0_timeout", 32'(busy0), 0);
        chk("q0_drained", q0.size(), 0);
    endtask

    initial begin
        rst = 0; tick = 0; rec0 = 0; rec1 = 0; note_in = 0;
        step();
        step();
        chk("rst_we", 32'(we0), 0);
        chk("rst_waddr", 32'(waddr0), 0);
        chk("rst_wdata", 32'(wdata0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_full", 32'(full0), 0);
        chk("rst_len", 32'(len0), 0);
        rst = 1;
        step();
        // basic melody
        q0.push_back(ent(0, 3, 4));
        q0.push_back(ent(1, 5, 2));
        q0.push_back(ent(2, 0, 0));
        rec0 = 1;
        step();
        chk("busy_run", 32'(busy0), 1);
        ticks(4, 3);
        ticks(2, 5);
        rec0 = 0;
        wait_idle0();
        chk("basic_len", 32'(len0), 2);
        chk("basic_full", 32'(full0), 0);
        // saturation
        q0.push_back(ent(0, 7, 255));
        q0.push_back(ent(1, 7, 45));
        q0.push_back(ent(2, 0, 0));
        rec0 = 1;
        step();
        ticks(300, 7);
        rec0 = 0;
        wait_idle0();
        chk("sat_len", 32'(len0), 2);
        // rec falls together with a tick
        q0.push_back(ent(0, 4, 2));
        q0.push_back(ent(1, 0, 0));
        rec0 = 1;
        step();
        ticks(2, 4);
        tick = 1;
        note_in = 4;
        rec0 = 0;
        step();
        tick = 0;
        wait_idle0();
        chk("simul_len", 32'(len0), 1);
        // empty take
        q0.push_back(ent(0, 0, 0));
        rec0 = 1;
        step();
        step();
        rec0 = 0;
        wait_idle0();
        chk("empty_len", 32'(len0), 0);
        // full memory on the small instance, rec held high through DONE
        for (int i = 0; i < 7; i++) q1.push_back(ent(i, (i % 2) ? 2 : 1, 1));
        q1.push_back(ent(7, 0, 0));
        rec1 = 1;
        step();
        for (int i = 0; i < 20; i++) ticks(1, (i % 2) ? 2 : 1);
        repeat (10) step();
        chk("full_flag", 32'(full1), 1);
        chk("full_len", 32'(len1), 7);
        chk("full_busy", 32'(busy1), 0);
        rec1 = 0;
        repeat (3) step();
        chk("full_sticky", 32'(full1), 1);
        chk("q1_drained", q1.size(), 0);
        // asynchronous reset mid-song
        q0.push_back(ent(0, 1, 1));
        q0.push_back(ent(1, 2, 1));
        rec0 = 1;
        step();
        ticks(1, 1);
        ticks(1, 2);
        ticks(1, 3);
        chk("pre_rst_len", 32'(len0), 2);
        rec0 = 0;
        rst = 0;
        #1;
        chk("arst_we", 32'(we0), 0);
        chk("arst_waddr", 32'(waddr0), 0);
        chk("arst_wdata", 32'(wdata0), 0);
        chk("arst_busy", 32'(busy0), 0);
        chk("arst_len", 32'(len0), 0);
        step();
        rst = 1;
        step();
        q0.push_back(ent(0, 6, 1));
        q0.push_back(ent(1, 9, 1));
        q0.push_back(ent(2, 0, 0));
        rec0 = 1;
        step();
        ticks(1, 6);
        ticks(1, 9);
        rec0 = 0;
        wait_idle0();
        chk("restart_len", 32'(len0), 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
